bit_stream_tx: RTL and testbench
================================

BIT_STREAM_TX -- requirements
Module: bit_stream_tx

Interface
REQ-001 SHALL have parameter CLK_LEN, default 32, width of bit-period count.
REQ-002 SHALL have parameter DATA_W, default 8, bits per word.
REQ-003 SHALL have parameter PREAMBLE_LEN, default 16, preamble bits per frame start.
REQ-004 SHALL have port clk_300M  input  1  base clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port bit_period  input  CLK_LEN  clk_300M cycles per transmitted bit.
REQ-007 SHALL have port tx_data  input  DATA_W  word to send, MSB first.
REQ-008 SHALL have port tx_valid  input  1  tx_data valid.
REQ-009 SHALL have port tx_ready  output  1  block accepts word this cycle.
REQ-010 SHALL have port signal  output  1  NRZ serial line.
REQ-011 SHALL have port bit_strobe  output  1  one-cycle pulse on first cycle of every driven bit.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, DATA.
REQ-014 Handshake SHALL occur on a cycle with tx_valid=1 and tx_ready=1; tx_data is captured on that edge.
REQ-015 tx_ready SHALL be 1 in IDLE, 1 on the final cycle of the last DATA bit, 0 otherwise.
REQ-016 On handshake in IDLE: latch bit_period (effective period), go PREAMBLE (macro defined) or DATA (macro undefined); the first bit SHALL appear on signal the next cycle, with bit_strobe=1.
REQ-017 Effective period SHALL be max(bit_period, 2); values 0 and 1 clamp to 2.
REQ-018 Each bit SHALL be held exactly effective-period cycles; the period counter counts 0..period-1 and advances the bit at period-1.
REQ-019 PREAMBLE SHALL drive PREAMBLE_LEN bits alternating 1,0,1,0..., then enter DATA.
REQ-020 DATA SHALL drive tx_data[DATA_W-1] down to tx_data[0].
REQ-021 Handshake on the last DATA bit's final cycle SHALL load the next word and its MSB the next cycle, with no gap and no preamble; bit_period is re-latched at that point.
REQ-022 Without a handshake at the last DATA bit's end: go IDLE; signal=0 the next cycle.
REQ-023 bit_period changes mid-frame SHALL be ignored until the next latch point.
REQ-024 In IDLE, signal SHALL be 0 and bit_strobe 0.
REQ-025 Period counter and bit index SHALL never wrap within a bit; bit_period={CLK_LEN{1}} SHALL be held exactly that many cycles.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, signal=0, bit_strobe=0, busy=0, tx_ready=1, counters 0, latched period 2.
REQ-027 Reset mid-frame SHALL abandon the word; after release, the next handshake starts a fresh frame.

Configuration
REQ-028 With macro BIT_STREAM_TX_PREAMBLE_EN defined, every frame started from IDLE SHALL send the preamble (REQ-019).
REQ-029 With BIT_STREAM_TX_PREAMBLE_EN undefined, PREAMBLE state and logic SHALL be absent; IDLE handshake goes directly to DATA.

Structure
REQ-030 Package bit_clk_pkg SHALL hold CLK_LEN, MIN_PERIOD=2, and the tx state enum type.
REQ-031 Sub-module bit_timer SHALL hold the period counter, clamp, and bit_strobe / bit_end pulse generation.

Verification
REQ-032 Reset, then no tx_valid for 100 cycles -> signal=0, tx_ready=1, busy=0 throughout.
REQ-033 Macro undefined, bit_period=4, send 0xA5 -> signal bits 1,0,1,0,0,1,0,1 each 4 cycles, starting 1 cycle after handshake; 8 strobes; then IDLE.
REQ-034 Macro defined, PREAMBLE_LEN=16, bit_period=10, send 0xFF -> 160 cycles of 1010... then 80 cycles high; busy for 240 cycles.
REQ-035 tx_valid held high with 0x01 then 0x80, bit_period=3 -> 16 contiguous bits, no idle cycle, preamble only before first word.
REQ-036 bit_period=0 -> each bit lasts 2 cycles; change bit_period 4->8 mid-frame -> current frame keeps 4.
REQ-037 rst_n pulsed low during bit 3 of DATA -> signal=0 asynchronously; a new 0x3C after release transmits correctly.

Source files
------------

// File: rtl/bit_clk_pkg.sv
// Shared constants and the transmit state type for bit_stream_tx.
// BIT_STREAM_TX_PREAMBLE_EN adds the PREAMBLE state.
package bit_clk_pkg;

    localparam int unsigned CLK_LEN    = 32;
    localparam int unsigned MIN_PERIOD = 2;

`ifdef BIT_STREAM_TX_PREAMBLE_EN
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd2
    } tx_state_t;
`endif

endpackage

// File: rtl/bit_stream_tx_bit_timer.sv
// Bit-period timer: latches and clamps the period, counts cycles within a bit,
// and produces the registered bit strobe plus combinational end-of-bit flags.
module bit_timer #(
    parameter int unsigned CLK_LEN = bit_clk_pkg::CLK_LEN
) (
    input  logic               clk_300M,
    input  logic               rst_n,
    input  logic [CLK_LEN-1:0] i_period,
    input  logic               i_load,
    input  logic               i_adv,
    input  logic               i_run,
    output logic               o_bit_strobe,
    output logic               o_bit_end_c,
    output logic               o_pre_end_c
);
    import bit_clk_pkg::*;

    localparam logic [CLK_LEN-1:0] MIN_P = CLK_LEN'(MIN_PERIOD);

    logic [CLK_LEN-1:0] r_cnt;
    logic [CLK_LEN-1:0] r_period;
    logic               r_strobe;
    logic [CLK_LEN-1:0] w_period_clamped;

    assign w_period_clamped = (i_period < MIN_P) ? MIN_P : i_period;

    // Period is always >= 2, so neither subtraction can underflow.
    assign o_bit_end_c = (r_cnt == (r_period - CLK_LEN'(1)));
    assign o_pre_end_c = (r_cnt == (r_period - CLK_LEN'(2)));

    always_ff @(posedge clk_300M or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_period <= MIN_P;
            r_strobe <= 1'b0;
        end else if (i_load) begin
            r_cnt    <= '0;
            r_period <= w_period_clamped;
            r_strobe <= 1'b1;
        end else if (i_adv) begin
            r_cnt    <= '0;
            r_strobe <= 1'b1;
        end else if (i_run) begin
            r_cnt    <= r_cnt + CLK_LEN'(1);
            r_strobe <= 1'b0;
        end else begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end
    end

    assign o_bit_strobe = r_strobe;

endmodule

// File: rtl/bit_stream_tx.sv
// NRZ serial word transmitter, MSB first, with back-to-back word chaining.
// Define BIT_STREAM_TX_PREAMBLE_EN to send an alternating preamble before each frame.
module bit_stream_tx #(
    parameter int unsigned CLK_LEN      = bit_clk_pkg::CLK_LEN,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned PREAMBLE_LEN = 16
) (
    input  logic               clk_300M,
    input  logic               rst_n,
    input  logic [CLK_LEN-1:0] bit_period,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               signal,
    output logic               bit_strobe,
    output logic               busy
);
    import bit_clk_pkg::*;

    localparam int unsigned IDX_MAX = (PREAMBLE_LEN > DATA_W) ? PREAMBLE_LEN : DATA_W;
    localparam int unsigned IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] w_word_nxt;
    logic              r_signal;
    logic              w_signal_nxt;
    logic              r_tx_ready;
    logic              w_tx_ready_nxt;
    logic              r_busy;
    logic              w_hs;
    logic              w_load;
    logic              w_adv;
    logic              w_run;
    logic              w_bit_end;
    logic              w_pre_end;

    assign w_hs  = tx_valid & r_tx_ready;
    assign w_run = (r_state != IDLE) & ~w_bit_end;

    bit_timer #(
        .CLK_LEN (CLK_LEN)
    ) u_bit_timer (
        .clk_300M     (clk_300M),
        .rst_n        (rst_n),
        .i_period     (bit_period),
        .i_load       (w_load),
        .i_adv        (w_adv),
        .i_run        (w_run),
        .o_bit_strobe (bit_strobe),
        .o_bit_end_c  (w_bit_end),
        .o_pre_end_c  (w_pre_end)
    );

    // Next-state, next-bit and ready prediction.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_word_nxt   = r_word;
        w_signal_nxt = r_signal;
        w_load       = 1'b0;
        w_adv        = 1'b0;

        case (r_state)
            IDLE: begin
                w_signal_nxt = 1'b0;
                if (w_hs) begin
                    w_load     = 1'b1;
                    w_word_nxt = tx_data;
`ifdef BIT_STREAM_TX_PREAMBLE_EN
                    w_state_nxt  = PREAMBLE;
                    w_idx_nxt    = IDX_W'(PREAMBLE_LEN - 1);
                    w_signal_nxt = 1'b1;
`else
                    w_state_nxt  = DATA;
                    w_idx_nxt    = IDX_W'(DATA_W - 1);
                    w_signal_nxt = tx_data[DATA_W-1];
`endif
                end
            end
`ifdef BIT_STREAM_TX_PREAMBLE_EN
            PREAMBLE: begin
                if (w_bit_end) begin
                    w_adv = 1'b1;
                    if (r_idx == '0) begin
                        w_state_nxt  = DATA;
                        w_idx_nxt    = IDX_W'(DATA_W - 1);
                        w_signal_nxt = r_word[DATA_W-1];
                    end else begin
                        w_idx_nxt    = r_idx - IDX_W'(1);
                        w_signal_nxt = ~r_signal;
                    end
                end
            end
`endif
            DATA: begin
                if (w_bit_end) begin
                    if (r_idx == '0) begin
                        if (w_hs) begin
                            // Chained word: no gap, no preamble, period re-latched.
                            w_load       = 1'b1;
                            w_word_nxt   = tx_data;
                            w_idx_nxt    = IDX_W'(DATA_W - 1);
                            w_signal_nxt = tx_data[DATA_W-1];
                        end else begin
                            w_state_nxt  = IDLE;
                            w_signal_nxt = 1'b0;
                        end
                    end else begin
                        w_adv        = 1'b1;
                        w_idx_nxt    = r_idx - IDX_W'(1);
                        w_word_nxt   = {r_word[DATA_W-2:0], 1'b0};
                        w_signal_nxt = r_word[DATA_W-2];
                    end
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_signal_nxt = 1'b0;
            end
        endcase

        // Ready next cycle in IDLE, or when next cycle is the final cycle of the last data bit.
        w_tx_ready_nxt = (w_state_nxt == IDLE) ||
                         ((w_state_nxt == DATA) && (w_idx_nxt == '0) &&
                          w_pre_end && !w_load && !w_adv);
    end

    always_ff @(posedge clk_300M or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_word     <= '0;
            r_signal   <= 1'b0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_word     <= w_word_nxt;
            r_signal   <= w_signal_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    assign tx_ready = r_tx_ready;
    assign signal   = r_signal;
    assign busy     = r_busy;

endmodule

// File: tb/tb_bit_stream_tx.sv
// Scoreboard bench for bit_stream_tx: stimulus queues expected bits with start cycles,
// a negedge monitor checks every strobed bit.
module tb_bit_stream_tx;

`ifdef BIT_STREAM_TX_PREAMBLE_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif
    localparam int PRE_LEN = 16;

    logic        clk_300M = 1'b0;
    logic        rst_n    = 1'b0;
    logic [31:0] bit_period = 32'd4;
    logic [7:0]  tx_data    = 8'h00;
    logic        tx_valid   = 1'b0;
    logic        tx_ready;
    logic        signal;
    logic        bit_strobe;
    logic        busy;

    bit_stream_tx #(
        .CLK_LEN      (32),
        .DATA_W       (8),
        .PREAMBLE_LEN (PRE_LEN)
    ) dut (
        .clk_300M   (clk_300M),
        .rst_n      (rst_n),
        .bit_period (bit_period),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .signal     (signal),
        .bit_strobe (bit_strobe),
        .busy       (busy)
    );

    always #5 clk_300M = ~clk_300M;

    typedef struct {
        logic b;
        int   start;
    } exp_t;

    exp_t sb_q[$];
    int   cyc       = 0;
    int   n_chk     = 0;
    int   n_fail    = 0;
    int   next_free = 0;
    int   busy_cnt  = 0;
    bit   pend      = 1'b0;
    bit   hold_err  = 1'b0;
    logic cur_bit   = 1'b0;

    always @(posedge clk_300M) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pop one expected bit per strobe; track that the line holds between strobes.
    always @(negedge clk_300M) begin
        if (busy) busy_cnt++;
        if (bit_strobe) begin
            if (pend) check("bit_hold", 32'(hold_err), 32'd0);
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_strobe at cycle %0d: got strobe expected none", cyc);
                pend = 1'b0;
            end else begin
                exp_t it;
                it = sb_q.pop_front();
                check("bit_value", 32'(signal), 32'(it.b));
                check("bit_start", 32'(cyc), 32'(it.start));
                pend     = 1'b1;
                hold_err = 1'b0;
                cur_bit  = it.b;
            end
        end else if (pend) begin
            if (!busy) begin
                check("bit_hold", 32'(hold_err), 32'd0);
                pend = 1'b0;
            end else if (signal !== cur_bit) begin
                hold_err = 1'b1;
            end
        end
    end

    // Called at a negedge; handshake happens on the next posedge where tx_ready is seen high.
    task automatic send_word(input logic [7:0] d, input logic [31:0] p, input bit chain);
        int   pe;
        int   hs;
        int   start;
        int   t;
        exp_t e;
        pe         = (p < 32'd2) ? 2 : int'(p);
        bit_period = p;
        tx_data    = d;
        tx_valid   = 1'b1;
        t          = 0;
        while (!tx_ready && t < 3000) begin
            @(negedge clk_300M);
            t++;
        end
        if (t >= 3000) begin
            check("ready_timeout", 32'(t), 32'd0);
        end
        hs = cyc + 1;
        if (chain) begin
            check("chain_handshake", 32'(hs), 32'(next_free));
            start = next_free;
        end else begin
            start = hs;
        end
        if (PRE_EN && !chain) begin
            for (int i = 0; i < PRE_LEN; i++) begin
                e.b     = ((i % 2) == 0);
                e.start = start + i * pe;
                sb_q.push_back(e);
            end
            start = start + PRE_LEN * pe;
        end
        for (int i = 0; i < 8; i++) begin
            e.b     = d[7-i];
            e.start = start + i * pe;
            sb_q.push_back(e);
        end
        next_free = start + 8 * pe;
        @(posedge clk_300M);
        @(negedge clk_300M);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (cyc < next_free && t < 5000) begin
            @(negedge clk_300M);
            t++;
        end
        check("idle_cycle", 32'(cyc), 32'(next_free));
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_signal", 32'(signal), 32'd0);
        check("idle_ready", 32'(tx_ready), 32'd1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        repeat (3) @(negedge clk_300M);
    endtask

    initial begin
        int data_start;
        repeat (3) @(negedge clk_300M);
        check("rst_signal", 32'(signal), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobe", 32'(bit_strobe), 32'd0);
        rst_n = 1'b1;

        // Idle for 100 cycles with no valid.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_300M);
            check("idle_signal", 32'(signal), 32'd0);
            check("idle_ready", 32'(tx_ready), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_strobe", 32'(bit_strobe), 32'd0);
        end

        // 0xA5 at period 4.
        busy_cnt = 0;
        send_word(8'hA5, 32'd4, 1'b0);
        tx_valid = 1'b0;
        wait_idle();
        check("busy_len_a5", 32'(busy_cnt), PRE_EN ? 32'd96 : 32'd32);

        // 0xFF at period 10.
        busy_cnt = 0;
        send_word(8'hFF, 32'd10, 1'b0);
        tx_valid = 1'b0;
        wait_idle();
        check("busy_len_ff", 32'(busy_cnt), PRE_EN ? 32'd240 : 32'd80);

        // Back-to-back 0x01 then 0x80 at period 3, valid held high.
        busy_cnt = 0;
        send_word(8'h01, 32'd3, 1'b0);
        send_word(8'h80, 32'd3, 1'b1);
        tx_valid = 1'b0;
        wait_idle();
        check("busy_len_chain", 32'(busy_cnt), PRE_EN ? 32'd96 : 32'd48);

        // Period 0 clamps to 2.
        send_word(8'h5A, 32'd0, 1'b0);
        tx_valid = 1'b0;
        wait_idle();

        // Period 1 clamps to 2.
        send_word(8'h96, 32'd1, 1'b0);
        tx_valid = 1'b0;
        wait_idle();

        // Mid-frame period change is ignored.
        send_word(8'hC3, 32'd4, 1'b0);
        tx_valid = 1'b0;
        repeat (6) @(negedge clk_300M);
        bit_period = 32'd8;
        wait_idle();

        // Reset during data bit 3 abandons the frame.
        send_word(8'h3C, 32'd4, 1'b0);
        tx_valid   = 1'b0;
        data_start = next_free - 32;
        while (cyc < data_start + 13) @(negedge clk_300M);
        #2 rst_n = 1'b0;
        #1;
        check("arst_signal", 32'(signal), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(tx_ready), 32'd1);
        check("arst_strobe", 32'(bit_strobe), 32'd0);
        sb_q.delete();
        pend = 1'b0;
        @(negedge clk_300M);
        @(negedge clk_300M);
        rst_n = 1'b1;
        @(negedge clk_300M);
        send_word(8'h3C, 32'd4, 1'b0);
        tx_valid = 1'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
